// File: rtl/sv_inv_iter.sv
// Iterative modular inverse x^-1 mod q (binary extended Euclid) for odd q.
// Rounds are chained ROUND_PER_TACT deep per clock; IDLE -> RUN -> FINISH control.
module sv_inv_iter #(
  parameter int DATA_WIDTH     = 512,
  parameter int ROUND_PER_TACT = 1,
  parameter int MAX_TACTS      = 4 * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] inv_o,
  output logic [15:0]           cycles_o
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  typedef struct packed {
    word_t a;
    word_t b;
    word_t s;
    word_t p;
  } round_t;

  localparam logic [15:0] MAX_T = 16'(MAX_TACTS);

  // Halve v modulo odd q: an odd v is made even by adding q in a widened sum.
  function automatic word_t half_mod(input word_t v, input word_t q);
    if (!v[0]) return v >> 1;
    return word_t'(({1'b0, v} + {1'b0, q}) >> 1);
  endfunction

  // When x < y the wrapped x - y + q lands exactly in [0, q-1].
  function automatic word_t sub_mod(input word_t x, input word_t y, input word_t q);
    if (x >= y) return x - y;
    return x - y + q;
  endfunction

  function automatic round_t one_round(input round_t r, input word_t q);
    round_t n;
    n = r;
    if (r.a == '0) begin
      n = r;
    end else if (!r.a[0]) begin
      n.a = r.a >> 1;
      n.s = half_mod(r.s, q);
    end else if (!r.b[0]) begin
      n.b = r.b >> 1;
      n.p = half_mod(r.p, q);
    end else if (r.a >= r.b) begin
      n.a = r.a - r.b;
      n.s = sub_mod(r.s, r.p, q);
    end else begin
      n.b = r.b - r.a;
      n.p = sub_mod(r.p, r.s, q);
    end
    return n;
  endfunction

  function automatic round_t one_tact(input round_t r, input word_t q);
    round_t n;
    n = r;
    for (int i = 0; i < ROUND_PER_TACT; i++) n = one_round(n, q);
    return n;
  endfunction

  state_t      state, state_nxt;
  round_t      cur, post;
  word_t       q_r;
  logic        input_bad;
  logic        timeout;
  logic [15:0] cyc_inc;

  assign input_bad = !q_i[0] || (q_i < word_t'(3)) || (x_i == '0) || (x_i >= q_i);
  assign post      = one_tact(cur, q_r);
  assign cyc_inc   = cycles_o + 16'd1;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == FINISH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    unique case (state)
      IDLE:   if (start_i) state_nxt = input_bad ? FINISH : RUN;
      RUN: begin
        if (post.a == '0) begin
          state_nxt = FINISH;
        end else if (cyc_inc >= MAX_T) begin
          state_nxt = FINISH;
          timeout   = 1'b1;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are registered on the edge entering FINISH so they are valid
  // during the done pulse and held afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur      <= '0;
      q_r      <= '0;
      inv_o    <= '0;
      err_o    <= 1'b0;
      cycles_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cur      <= '{a: x_i, b: q_i, s: word_t'(1), p: '0};
            q_r      <= q_i;
            inv_o    <= '0;
            err_o    <= input_bad;
            cycles_o <= '0;
          end
        end
        RUN: begin
          cur      <= post;
          cycles_o <= cyc_inc;
          if (post.a == '0) begin
            if (post.b == word_t'(1)) inv_o <= post.p;
            else                      err_o <= 1'b1;
          end else if (timeout) begin
            err_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
